// File: rtl/bmlp_seq_pkg.sv
// Shared types and layer geometry for the binarized-MLP layer sequencer.
// IN_LAST/OUT_LAST hold the last input-word and last output-neuron index of each layer.
package bmlp_seq_pkg;

  localparam int NUM_LAYERS = 3;
  localparam int IDX_W      = 7;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    COMMIT,
    NXT_LAYER,
    FIN
  } seq_state_t;

  localparam logic [IDX_W-1:0] IN_LAST  [NUM_LAYERS] = '{IDX_W'(24), IDX_W'(1),  IDX_W'(0)};
  localparam logic [IDX_W-1:0] OUT_LAST [NUM_LAYERS] = '{IDX_W'(63), IDX_W'(31), IDX_W'(9)};

  // Out-of-range layer numbers read as 0 so the indices can never run away.
  function automatic logic [IDX_W-1:0] in_last_of(input logic [1:0] layer);
    return (int'(layer) < NUM_LAYERS) ? IN_LAST[layer] : '0;
  endfunction

  function automatic logic [IDX_W-1:0] out_last_of(input logic [1:0] layer);
    return (int'(layer) < NUM_LAYERS) ? OUT_LAST[layer] : '0;
  endfunction

endpackage

// File: rtl/seq_idx_counter.sv
// Saturating index counter: clears to 0, increments only while below last_val.
// is_last is a combinational compare of the registered count against last_val.
module seq_idx_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last_val,
  output logic         is_last,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  assign is_last = (r_cnt == last_val);
  assign cnt     = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !is_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bmlp_layer_sequencer.sv
// Walks layers x output neurons x input words for one binarized-MLP inference.
// Strobes are a Moore decode of the state masked by hold; hold freezes state and indices.
module bmlp_layer_sequencer
  import bmlp_seq_pkg::*;
#(
  parameter int NUM_LAYERS = bmlp_seq_pkg::NUM_LAYERS,
  parameter int IDX_W      = bmlp_seq_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [1:0]       layer_idx,
  output logic [IDX_W-1:0] neuron_idx,
  output logic [IDX_W-1:0] word_idx,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             neuron_wr,
  output logic             layer_done
);

  seq_state_t       r_state;
  logic [1:0]       r_layer;

  logic             w_run;
  logic             w_last_layer;
  logic             w_word_last;
  logic             w_neur_last;
  logic             w_word_clr;
  logic             w_word_inc;
  logic             w_neur_clr;
  logic             w_neur_inc;
  logic [IDX_W-1:0] w_in_last;
  logic [IDX_W-1:0] w_out_last;

  assign w_run        = !hold;
  assign w_last_layer = (r_layer == 2'(NUM_LAYERS - 1));
  assign w_in_last    = IDX_W'(in_last_of(r_layer));
  assign w_out_last   = IDX_W'(out_last_of(r_layer));

  // IDLE keeps both counters at 0 so every inference starts from a clean origin.
  assign w_word_clr = (r_state == IDLE)
                    | (w_run & (r_state == COMMIT)    & !w_neur_last)
                    | (w_run & (r_state == NXT_LAYER) & !w_last_layer);
  assign w_word_inc = w_run & (r_state == ACCUM);
  assign w_neur_clr = (r_state == IDLE)
                    | (w_run & (r_state == NXT_LAYER) & !w_last_layer);
  assign w_neur_inc = w_run & (r_state == COMMIT);

  seq_idx_counter #(.W(IDX_W)) u_word_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_word_clr),
    .inc      (w_word_inc),
    .last_val (w_in_last),
    .is_last  (w_word_last),
    .cnt      (word_idx)
  );

  seq_idx_counter #(.W(IDX_W)) u_neur_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_neur_clr),
    .inc      (w_neur_inc),
    .last_val (w_out_last),
    .is_last  (w_neur_last),
    .cnt      (neuron_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_layer <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_state <= CLEAR;
        r_layer <= '0;
      end
    end else if (w_run) begin
      case (r_state)
        CLEAR:     r_state <= ACCUM;
        ACCUM:     if (w_word_last) r_state <= COMMIT;
        COMMIT:    r_state <= w_neur_last ? NXT_LAYER : CLEAR;
        NXT_LAYER: begin
          if (w_last_layer) begin
            r_state <= FIN;
          end else begin
            r_state <= CLEAR;
            r_layer <= r_layer + 2'd1;
          end
        end
        FIN:       r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign layer_idx  = r_layer;
  assign acc_clr    = w_run & (r_state == CLEAR);
  assign acc_en     = w_run & (r_state == ACCUM);
  assign neuron_wr  = w_run & (r_state == COMMIT);
  assign layer_done = w_run & (r_state == NXT_LAYER);
  assign done       = w_run & (r_state == FIN);

endmodule

// File: tb/tb_bmlp_layer_sequencer.sv
// Bench: per-cycle expectation queue built from the layer/neuron/word loop nest,
// plus a table of fixed-cycle checks and hand-written hold/reset/start sequences.
module tb_bmlp_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       hold;
  logic       busy;
  logic       done;
  logic [1:0] layer_idx;
  logic [6:0] neuron_idx;
  logic [6:0] word_idx;
  logic       acc_clr;
  logic       acc_en;
  logic       neuron_wr;
  logic       layer_done;

  int total = 0;
  int bad   = 0;

  int in_last  [3] = '{24, 1, 0};
  int out_last [3] = '{63, 31, 9};

  typedef struct {
    logic       clr, en, wr, ld, dn;
    logic [1:0] l;
    logic [6:0] n, w;
    bit         cn, cw;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [5:0] mask;
    logic [5:0] val;
    string      nm;
  } tv_t;

  exp_t       q[$];
  logic [5:0] tr_ctl [0:2047];
  logic [1:0] tr_lay [0:2047];

  always #5 clk = ~clk;

  bmlp_layer_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .layer_idx  (layer_idx),
    .neuron_idx (neuron_idx),
    .word_idx   (word_idx),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .neuron_wr  (neuron_wr),
    .layer_done (layer_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One entry per un-held busy cycle: clear, one accumulate per word, commit; layer end; finish.
  function automatic void build_model();
    q.delete();
    for (int l = 0; l < 3; l++) begin
      for (int n = 0; n <= out_last[l]; n++) begin
        q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(l), 7'(n), 7'd0, 1'b1, 1'b1});
        for (int w = 0; w <= in_last[l]; w++)
          q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(l), 7'(n), 7'(w), 1'b1, 1'b1});
        q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'(l), 7'(n), 7'(in_last[l]), 1'b1, 1'b1});
      end
      q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'(l), 7'(out_last[l]), 7'd0, 1'b1, 1'b0});
    end
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 7'd0, 7'd0, 1'b0, 1'b0});
  endfunction

  task automatic run_inf(input int hold_pct, input bit noise, output int ncyc);
    exp_t       e;
    int         cyc;
    logic [7:0] act;
    logic [7:0] ex;
    build_model();
    @(posedge clk); #1; start = 1'b1; hold = 1'b0; #1;
    chk("idle_busy", 32'(busy), 0);
    cyc = 0;
    while (q.size() > 0 && cyc < 6000) begin
      @(posedge clk); #1; cyc++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      hold  = ($urandom_range(0, 99) < hold_pct);
      #1;
      e   = q[0];
      act = {busy, acc_clr, acc_en, neuron_wr, layer_done, done, layer_idx};
      ex  = hold ? {1'b1, 5'b0, e.l} : {1'b1, e.clr, e.en, e.wr, e.ld, e.dn, e.l};
      chk("ctl", 32'(act), 32'(ex));
      if (e.cn) chk("neuron_idx", 32'(neuron_idx), 32'(e.n));
      if (e.cw) chk("word_idx", 32'(word_idx), 32'(e.w));
      if (cyc < 2048) begin
        tr_ctl[cyc] = act[7:2];
        tr_lay[cyc] = layer_idx;
      end
      if (!hold) void'(q.pop_front());
    end
    if (q.size() != 0) chk("run_timeout", 32'(q.size()), 0);
    @(posedge clk); #1; start = 1'b0; hold = 1'b0; #1; cyc++;
    chk("end_idle", 32'({busy, done}), 0);
    if (cyc < 2048) tr_ctl[cyc] = {busy, acc_clr, acc_en, neuron_wr, layer_done, done};
    ncyc = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tv_t tbl[11];
    int  n;
    int  cyc;
    int  cnt_wr;
    int  cnt_en;
    int  dn;
    bit  found;

    tbl[0]  = '{1,    6'b010000, 6'b010000, "clr_c1"};
    tbl[1]  = '{2,    6'b001000, 6'b001000, "en_c2"};
    tbl[2]  = '{1728, 6'b000110, 6'b000100, "wr_c1728"};
    tbl[3]  = '{1729, 6'b000110, 6'b000010, "ld_c1729"};
    tbl[4]  = '{1858, 6'b000010, 6'b000010, "ld_c1858"};
    tbl[5]  = '{1889, 6'b000011, 6'b000010, "ld_c1889"};
    tbl[6]  = '{1890, 6'b100011, 6'b100001, "done_c1890"};
    tbl[7]  = '{1891, 6'b111111, 6'b000000, "idle_c1891"};
    tbl[8]  = '{1859, 6'b010000, 6'b010000, "l2_clr_c1859"};
    tbl[9]  = '{1860, 6'b001000, 6'b001000, "l2_en_c1860"};
    tbl[10] = '{1861, 6'b000100, 6'b000100, "l2_wr_c1861"};

    rst = 1'b0; start = 1'b0; hold = 1'b0;
    #2;
    chk("reset_outputs", 32'({busy, done, acc_clr, acc_en, neuron_wr, layer_done,
                               layer_idx, neuron_idx, word_idx}), 0);
    #21; rst = 1'b1;

    // Full run with no hold; fixed-cycle table and per-layer strobe counts from the trace.
    run_inf(0, 1'b0, n);
    chk("full_cycles", 32'(n), 1891);
    for (int i = 0; i < 11; i++)
      chk(tbl[i].nm, 32'(tr_ctl[tbl[i].cyc] & tbl[i].mask), 32'(tbl[i].val));
    cnt_wr = 0; cnt_en = 0;
    for (int c = 1; c <= 1890; c++) begin
      if (tr_lay[c] == 2'd0 && tr_ctl[c][2]) cnt_wr++;
      if (tr_lay[c] == 2'd0 && tr_ctl[c][3]) cnt_en++;
    end
    chk("l0_wr_count", 32'(cnt_wr), 64);
    chk("l0_en_count", 32'(cnt_en), 1600);

    // Five held cycles while sitting on word 10 of the first neuron.
    @(posedge clk); #1; start = 1'b1; hold = 1'b0; #1;
    cyc = 0; found = 1'b0;
    while (!found && cyc < 100) begin
      @(posedge clk); #1; start = 1'b0; cyc++; #1;
      if (acc_en && word_idx == 7'd9 && layer_idx == 2'd0 && neuron_idx == 7'd0) found = 1'b1;
    end
    chk("hold_reach_w9", 32'(cyc), 11);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; hold = 1'b1; cyc++; #1;
      chk("hold_frozen", 32'({busy, acc_clr, acc_en, neuron_wr, layer_done, done, word_idx}),
          32'({1'b1, 5'b0, 7'd10}));
    end
    @(posedge clk); #1; hold = 1'b0; cyc++; #1;
    chk("hold_resume_w10", 32'({acc_en, word_idx}), 32'({1'b1, 7'd10}));
    @(posedge clk); #1; cyc++; #1;
    chk("hold_resume_w11", 32'({acc_en, word_idx}), 32'({1'b1, 7'd11}));
    while (!done && cyc < 3000) begin
      @(posedge clk); #1; cyc++; #1;
    end
    chk("hold_done_cycle", 32'(cyc), 1895);
    @(posedge clk); #1; #1;
    chk("hold_end_idle", 32'(busy), 0);

    // Random hold and random start noise against the model.
    run_inf(30, 1'b1, n);

    // Asynchronous reset in the middle of layer 0.
    @(posedge clk); #1; start = 1'b1; #1;
    cyc = 0;
    while (cyc < 500) begin
      @(posedge clk); #1; start = 1'b0; cyc++; #1;
    end
    chk("pre_reset_busy", 32'(busy), 1);
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("mid_reset_outputs", 32'({busy, done, acc_clr, acc_en, neuron_wr, layer_done,
                                   layer_idx, neuron_idx, word_idx}), 0);
    @(posedge clk); #1; #1;
    chk("mid_reset_held", 32'({busy, acc_clr, acc_en, neuron_wr, layer_done, done}), 0);
    rst = 1'b1;
    run_inf(20, 1'b1, n);

    // start held high for the whole run: exactly one inference, then a fresh one from IDLE.
    @(posedge clk); #1; start = 1'b1; hold = 1'b0; #1;
    cyc = 0; dn = 0; found = 1'b0;
    while (!found && cyc < 2500) begin
      @(posedge clk); #1; cyc++; #1;
      if (done) dn++;
      if (!busy) found = 1'b1;
    end
    chk("sh_done_count", 32'(dn), 1);
    chk("sh_idle_cycle", 32'(cyc), 1891);
    @(posedge clk); #1; #1;
    chk("sh_restart", 32'({busy, acc_clr, layer_idx, neuron_idx}), 32'({1'b1, 1'b1, 2'd0, 7'd0}));
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
